inv_key_sched: RTL and testbench
================================

Name: inv_key_sched

Overview:
Sequential inverse key scheduler for the 16-bit AES decryption path. It loads the final-round key once, then walks backwards through the key schedule, one round key per handshake. It streams round keys 10 down to 0 to the downstream inverse round datapath over a valid/ready interface. It iterates a single combinational inverse key-expansion step rather than storing a precomputed schedule.

Parameters:
NUM_ROUNDS, 10, number of rounds; keys emitted = NUM_ROUNDS+1
KEY_W, 16, round key width in bits

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; load key_in and begin a schedule
key_in  input  KEY_W  final-round (round 10) key, sampled when start is accepted
key_out  output  KEY_W  current round key
round  output  4  round index of key_out (10..0)
key_valid  output  1  key_out/round are valid
key_ready  input  1  downstream accepts key_out this cycle
busy  output  1  schedule in progress; start is ignored while high
done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (clk edge with rst=1): state IDLE. key_out=0, round=0, key_valid=0, busy=0, done=0. Internal count=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 → key_reg<=key_in, round<=10, count<=0, key_valid<=1, busy<=1, go RUN.
  - start=0 → stay.
- RUN, per cycle:
  - key_valid&&key_ready, round>0 → key_reg<=step(key_reg,count), round<=round-1, count<=count+1. key_valid stays 1, so there are no bubbles.
  - key_valid&&key_ready, round==0 → key_valid<=0, go FIN.
  - key_ready=0 → key_out, round and count hold stable. Valid is never withdrawn.
- FIN: done=1 for exactly one cycle, busy<=0, go IDLE. A start in FIN is ignored; start is accepted again from the next cycle in IDLE.
- step(k,c) = k XOR invSub(k) XOR rcon(c):
  - invSub is the team's existing invSubByte mapping.
  - rcon(c), c=0..9: 0x3600, 0x1b00, 0x8000, 0x4000, 0x2000, 0x1000, 0x0800, 0x0400, 0x0200, 0x0100.
  - rcon = 0 for any other value of c.
  - Round r → r-1 uses count c = 10-r.
- Latency: first key valid in the cycle after start is accepted. 11 keys in 11 cycles when key_ready is held at 1. done follows one cycle after the last accept.
- start while busy: ignored; no reload and no state change.
- rst mid-schedule: immediate return to IDLE with reset values. No done pulse.
- key_ready asserted while key_valid=0: no effect.

Optional Feature:
Macro KEY_CACHE_EN.
- Defined:
  - An 11-entry KEY_W register file is written with each key as it is emitted, plus a tag register holding key_in.
  - A start whose key_in equals the tag of a fully completed schedule sets output cache_hit=1 for that schedule. key_out is then read from the cache indexed by round, and the step logic is bypassed.
  - Handshake and timing are identical to the uncached path.
  - Reset clears the tag-valid flag.
- Undefined: no cache storage and no cache_hit port; keys are always recomputed.

Decomposition:
- Shared package aes16_pkg:
  - KEY_W and NUM_ROUNDS constants.
  - Round index type (4-bit).
  - FSM state enum.
  - The rcon table as a constant function.
- One sub-module: inv_key_step, purely combinational (key, count → next key). It wraps the invSubByte mapping and the rcon XOR. It is instantiated once and exercised stand-alone in unit tests.

Test Plan:
- key_in=0x0000, start, key_ready=1 → 11 consecutive valid cycles with round 10,9,…,0. First key_out=0x0000; second = invSub(0x0000)^0x3600 (0x6452 under the AES inverse S-box). done pulses once, one cycle after round 0.
- Backpressure: key_ready=0 for 3 cycles at round 7 → key_out and round stable, key_valid held at 1. Sequence resumes at round 6 with no key skipped or duplicated.
- start pulsed at round 5 while busy → ignored. Sequence continues to round 0 unchanged.
- rst asserted at round 4 → next cycle key_valid=0, busy=0, round=0, no done. A fresh start then begins at round 10.
- Reference-model check: 64 random key_in values, each emitted key compared against a software inverse schedule applying rcon in order 0x36,0x1b,0x80,…,0x01.
- KEY_CACHE_EN: same key_in twice → second run has cache_hit=1 and identical key_out sequence. Different key_in → cache_hit=0.

Source files
------------

// File: rtl/aes16_pkg.sv
// Shared constants, types and round-constant table for the 16-bit AES key path.
package aes16_pkg;

  localparam int KEY_W      = 16;
  localparam int NUM_ROUNDS = 10;

  typedef logic [3:0] round_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_e;

  // Constants are consumed in reverse order while walking the schedule backwards.
  function automatic logic [KEY_W-1:0] rcon(input round_t c);
    case (c)
      4'd0:    rcon = 16'h3600;
      4'd1:    rcon = 16'h1b00;
      4'd2:    rcon = 16'h8000;
      4'd3:    rcon = 16'h4000;
      4'd4:    rcon = 16'h2000;
      4'd5:    rcon = 16'h1000;
      4'd6:    rcon = 16'h0800;
      4'd7:    rcon = 16'h0400;
      4'd8:    rcon = 16'h0200;
      4'd9:    rcon = 16'h0100;
      default: rcon = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// One combinational inverse key-expansion step: k ^ invSub(k) ^ rcon(count).
module inv_key_step
  import aes16_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  round_t           count_i,
  output logic [KEY_W-1:0] key_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign key_o = key_i ^ {INV_SBOX[key_i[15:8]], INV_SBOX[key_i[7:0]]} ^ rcon(count_i);

endmodule

// File: rtl/inv_key_sched.sv
// Inverse key scheduler: streams round keys 10..0 over valid/ready from the final-round key.
// Optional replay cache of the last completed schedule enabled by `define KEY_CACHE_EN.
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_RUN  | key_out/round valid, advancing one round per accept
// ST_FIN  | round 0 accepted, done pulse
module inv_key_sched
  import aes16_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_in_i,
  output logic [KEY_W-1:0] key_out_o,
  output logic [3:0]       round_o,
  output logic             key_valid_o,
  input  logic             key_ready_i,
  output logic             busy_o,
  output logic             done_o
`ifdef KEY_CACHE_EN
  ,
  output logic             cache_hit_o
`endif
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  round_t           round_q, round_d;
  round_t           count_q, count_d;
  logic [KEY_W-1:0] step_key;

  inv_key_step u_step (
    .key_i   (key_q),
    .count_i (count_q),
    .key_o   (step_key)
  );

`ifdef KEY_CACHE_EN
  logic [KEY_W-1:0] cache_q [NUM_ROUNDS+1];
  logic [KEY_W-1:0] tag_q, tag_d;
  logic             tag_vld_q, tag_vld_d;
  logic             hit_q, hit_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      count_q <= '0;
`ifdef KEY_CACHE_EN
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      hit_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      count_q <= count_d;
`ifdef KEY_CACHE_EN
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      hit_q     <= hit_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    count_d = count_q;
`ifdef KEY_CACHE_EN
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    hit_d     = hit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          key_d   = key_in_i;
          round_d = round_t'(NUM_ROUNDS);
          count_d = '0;
          state_d = ST_RUN;
`ifdef KEY_CACHE_EN
          hit_d = tag_vld_q && (key_in_i == tag_q);
          // A miss overwrites the cache, so the old tag is no longer trustworthy.
          if (!hit_d) begin
            tag_d     = key_in_i;
            tag_vld_d = 1'b0;
          end
`endif
        end
      end
      ST_RUN: begin
        if (key_ready_i) begin
          if (round_q != 4'd0) begin
`ifdef KEY_CACHE_EN
            if (!hit_q) key_d = step_key;
`else
            key_d = step_key;
`endif
            round_d = round_q - 4'd1;
            count_d = count_q + 4'd1;
          end else begin
            state_d = ST_FIN;
`ifdef KEY_CACHE_EN
            tag_vld_d = 1'b1;
`endif
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef KEY_CACHE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_RUN && key_ready_i && !hit_q)
      cache_q[round_q] <= key_q;
  end

  assign key_out_o   = hit_q ? cache_q[round_q] : key_q;
  assign cache_hit_o = hit_q;
`else
  assign key_out_o = key_q;
`endif

  assign round_o     = round_q;
  assign key_valid_o = (state_q == ST_RUN);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_FIN);

endmodule

// File: tb/tb_inv_key_sched.sv
// Randomized bench for inv_key_sched against a GF(2^8)-derived inverse key schedule model.
module tb_inv_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] key_in;
  logic [15:0] key_out;
  logic [3:0]  round;
  logic        key_valid;
  logic        key_ready;
  logic        busy;
  logic        done;
`ifdef KEY_CACHE_EN
  logic        cache_hit;
`endif

  logic [15:0] st_k;
  logic [3:0]  st_c;
  logic [15:0] st_o;

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .key_in_i    (key_in),
    .key_out_o   (key_out),
    .round_o     (round),
    .key_valid_o (key_valid),
    .key_ready_i (key_ready),
    .busy_o      (busy),
    .done_o      (done)
`ifdef KEY_CACHE_EN
    ,
    .cache_hit_o (cache_hit)
`endif
  );

  inv_key_step u_step_ut (
    .key_i   (st_k),
    .count_i (st_c),
    .key_o   (st_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: inverse S-box derived from GF(2^8) inversion plus the AES affine map.
  logic [7:0]  isb [256];
  logic [15:0] rc_tb [10];
  logic [15:0] exp_keys [11];
  logic [15:0] seen_second;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_isb();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isb[s] = 8'(a);
    end
    rc_tb = '{16'h3600, 16'h1b00, 16'h8000, 16'h4000, 16'h2000,
              16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100};
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] k, input int c);
    logic [15:0] r = (c >= 0 && c < 10) ? rc_tb[c] : 16'h0000;
    return k ^ {isb[k[15:8]], isb[k[7:0]]} ^ r;
  endfunction

  task automatic build_exp(input logic [15:0] k);
    exp_keys[0] = k;
    for (int i = 0; i < 10; i++) exp_keys[i+1] = ref_step(exp_keys[i], i);
  endtask

  // Called at posedge+1; drives one schedule and checks every emitted key.
  task automatic run_sched(input logic [15:0] k, input int stall_rnd, input int stall_n,
                           input int poke_rnd, input int rst_rnd, input bit fin_poke);
    int idx = 0;
    int stalls = 0;
    int cyc = 0;
    bit poked = 0;
    bit finished = 0;
    build_exp(k);
    start = 1'b1; key_in = k; key_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = 16'($urandom);
    while (!finished && cyc < 64) begin
      chk("valid", 32'(key_valid), 32'd1);
      chk("round", 32'(round), 32'(10 - idx));
      chk("key", 32'(key_out), 32'(exp_keys[idx]));
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (idx == 1) seen_second = key_out;
      if (rst_rnd == 10 - idx) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_key", 32'(key_out), 32'd0);
        return;
      end
      key_ready = 1'b1;
      if (10 - idx == stall_rnd && stalls < stall_n) begin
        key_ready = 1'b0;
        stalls++;
      end
      if (10 - idx == poke_rnd && !poked) begin
        start = 1'b1; key_in = ~k; poked = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (key_ready) begin
        if (idx == 10) finished = 1;
        else idx++;
      end
    end
    chk("sched_in_budget", 32'(finished), 32'd1);
    chk("cycles", 32'(cyc), 32'(11 + stall_n));
    chk("done_pulse", 32'(done), 32'd1);
    chk("fin_valid", 32'(key_valid), 32'd0);
    chk("fin_busy", 32'(busy), 32'd1);
    key_ready = 1'b1;
    if (fin_poke) begin
      start = 1'b1; key_in = ~k;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_once", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(key_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] kc;
    build_isb();
    rst = 1'b1; start = 1'b0; key_in = 16'h0000; key_ready = 1'b0;
    st_k = 16'h0000; st_c = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key", 32'(key_out), 32'd0);
    chk("reset_round", 32'(round), 32'd0);
    chk("reset_valid", 32'(key_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // ready with nothing valid must not disturb the idle state
    key_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready_valid", 32'(key_valid), 32'd0);
      chk("idle_ready_round", 32'(round), 32'd0);
    end

    // stand-alone step unit, including out-of-table counts
    #1;
    chk("step_zero", 32'(st_o), 32'h6452);
    for (int i = 0; i < 40; i++) begin
      st_k = 16'($urandom);
      st_c = 4'($urandom_range(0, 15));
      #1;
      chk("step_rand", 32'(st_o), 32'(ref_step(st_k, int'(st_c))));
    end
    @(posedge clk); #1;

    run_sched(16'h0000, -1, 0, -1, -1, 1'b0);
    chk("second_key_0000", 32'(seen_second), 32'h6452);
    run_sched(16'($urandom), 7, 3, -1, -1, 1'b0);
    run_sched(16'($urandom), -1, 0, 5, -1, 1'b1);
    run_sched(16'($urandom), -1, 0, -1, 4, 1'b0);
    run_sched(16'($urandom), -1, 0, -1, -1, 1'b0);

    for (int i = 0; i < 64; i++)
      run_sched(16'($urandom), int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), -1, -1, 1'b0);

`ifdef KEY_CACHE_EN
    kc = 16'($urandom);
    run_sched(kc, -1, 0, -1, -1, 1'b0);
    chk("cache_first_miss", 32'(cache_hit), 32'd0);
    run_sched(kc, 3, 2, -1, -1, 1'b0);
    chk("cache_repeat_hit", 32'(cache_hit), 32'd1);
    run_sched(kc ^ 16'h0001, -1, 0, -1, -1, 1'b0);
    chk("cache_other_miss", 32'(cache_hit), 32'd0);
`else
    kc = 16'h0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
